wb_regfile: RTL and testbench

- Writeback-side consumer of the W pipeline register in the Y86-64 pipeline.
- Contains the 15-entry 64-bit architectural register file. Registers are written from the E and M result ports of the W stage and read combinationally by decode.
- Owns the processor status latch, which halts commits on the first non-AOK status to reach writeback.
- Counts retired instructions for performance and debug.

---
 rtl/y86_pkg.sv | 38 +++
 rtl/rf_core.sv | 78 +++++++
 rtl/wb_regfile.sv | 92 +++++++++
 tb/tb_wb_regfile.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 pipeline constants and types.
// Holds status codes, icodes, special register IDs and the basic
// register-ID / machine-word typedefs used across the pipeline.
package y86_pkg;

  typedef logic [3:0]  reg_id_t;
  typedef logic [63:0] word_t;
  typedef logic [3:0]  stat_t;
  typedef logic [3:0]  icode_t;

  // Processor status codes
  localparam stat_t SBUB = 4'h0;
  localparam stat_t SAOK = 4'h1;
  localparam stat_t SHLT = 4'h2;
  localparam stat_t SADR = 4'h3;
  localparam stat_t SINS = 4'h4;

  // Instruction codes
  localparam icode_t IHALT   = 4'h0;
  localparam icode_t INOP    = 4'h1;
  localparam icode_t IRRMOVQ = 4'h2;
  localparam icode_t IIRMOVQ = 4'h3;
  localparam icode_t IRMMOVQ = 4'h4;
  localparam icode_t IMRMOVQ = 4'h5;
  localparam icode_t IOPQ    = 4'h6;
  localparam icode_t IJXX    = 4'h7;
  localparam icode_t ICALL   = 4'h8;
  localparam icode_t IRET    = 4'h9;
  localparam icode_t IPUSHQ  = 4'hA;
  localparam icode_t IPOPQ   = 4'hB;

  // Special register IDs
  localparam reg_id_t RRSP  = 4'h4;
  localparam reg_id_t RNONE = 4'hF;

  localparam int unsigned NUM_REGS = 15;

endpackage

// File: rtl/rf_core.sv
// rf_core: 15 x 64-bit register storage, two write ports (E, M) and two
// combinational read ports. When both write ports target the same
// register, the M port wins (popq %rsp). Optional RF_WRITE_BYPASS_EN makes
// the current cycle's qualifying writes visible on the read ports.
module rf_core
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_RSP = 64'h0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    we,       // qualified commit for this cycle
  input  reg_id_t dst_e,
  input  word_t   val_e,
  input  reg_id_t dst_m,
  input  word_t   val_m,
  input  reg_id_t src_a,
  input  reg_id_t src_b,
  output word_t   rval_a,
  output word_t   rval_b
);

  word_t regs_q [NUM_REGS];

  logic we_e;
  logic we_m;

  assign we_e = we && (dst_e != RNONE);
  assign we_m = we && (dst_m != RNONE);

  // Storage update: M port takes priority over E port on the same register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == int'(RRSP)) ? RESET_RSP : 64'h0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_m && (dst_m == reg_id_t'(i))) begin
          regs_q[i] <= val_m;
        end else if (we_e && (dst_e == reg_id_t'(i))) begin
          regs_q[i] <= val_e;
        end
      end
    end
  end

  // Read port A: RNONE reads as zero; optional same-cycle write bypass
  always_comb begin
    rval_a = 64'h0;
    if (src_a != RNONE) begin
      rval_a = regs_q[src_a];
`ifdef RF_WRITE_BYPASS_EN
      if (we_m && (dst_m == src_a)) begin
        rval_a = val_m;
      end else if (we_e && (dst_e == src_a)) begin
        rval_a = val_e;
      end
`endif
    end
  end

  // Read port B: same behaviour as port A
  always_comb begin
    rval_b = 64'h0;
    if (src_b != RNONE) begin
      rval_b = regs_q[src_b];
`ifdef RF_WRITE_BYPASS_EN
      if (we_m && (dst_m == src_b)) begin
        rval_b = val_m;
      end else if (we_e && (dst_e == src_b)) begin
        rval_b = val_e;
      end
`endif
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: Y86-64 writeback stage. Commits W-stage results to the
// architectural register file, latches the first non-AOK status (halting
// further commits until reset) and counts retired non-nop instructions.
// Optional feature macro: RF_WRITE_BYPASS_EN (same-cycle read bypass in rf_core).
//
// Flow control: W_stall is a hold, not a handshake. With W_stall high the
// W inputs are ignored for that edge (no writes, no status change, no count).
module wb_regfile
  import y86_pkg::*;
#(
  parameter int unsigned RETIRE_W  = 32,
  parameter logic [63:0] RESET_RSP = 64'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                W_stall,
  input  logic [3:0]          W_stat,
  input  logic [3:0]          W_icode,
  input  logic [3:0]          W_dstE,
  input  logic [3:0]          W_dstM,
  input  logic [63:0]         W_valE,
  input  logic [63:0]         W_valM,
  input  logic [3:0]          d_srcA,
  input  logic [3:0]          d_srcB,
  output logic [63:0]         d_rvalA,
  output logic [63:0]         d_rvalB,
  output logic [3:0]          proc_stat,
  output logic                halted,
  output logic [RETIRE_W-1:0] retire_cnt
);

  stat_t               stat_q,   stat_d;
  logic                halted_q, halted_d;
  logic [RETIRE_W-1:0] cnt_q,    cnt_d;

  logic active;
  logic commit;
  logic fault;

  // An instruction is considered only when W advances and we are not halted
  assign active = !W_stall && !halted_q;
  assign commit = active && (W_stat == SAOK);
  assign fault  = active && (W_stat != SAOK) && (W_stat != SBUB);

  rf_core #(
    .RESET_RSP (RESET_RSP)
  ) u_rf_core (
    .clk    (clk),
    .rst    (rst),
    .we     (commit),
    .dst_e  (W_dstE),
    .val_e  (W_valE),
    .dst_m  (W_dstM),
    .val_m  (W_valM),
    .src_a  (d_srcA),
    .src_b  (d_srcB),
    .rval_a (d_rvalA),
    .rval_b (d_rvalB)
  );

  // Next-state: sticky status latch and wrapping retire counter
  always_comb begin
    stat_d   = stat_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (fault) begin
      stat_d   = W_stat;
      halted_d = 1'b1;
    end
    if (commit && (W_icode != INOP)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q   <= SAOK;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stat_q   <= stat_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign proc_stat  = stat_q;
  assign halted     = halted_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
// Built with RETIRE_W=4 so the counter wrap is reachable in a few cycles,
// and RESET_RSP=64'h200.
module tb_wb_regfile;

  localparam int unsigned RW = 4;

  logic          clk;
  logic          rst;
  logic          W_stall;
  logic [3:0]    W_stat;
  logic [3:0]    W_icode;
  logic [3:0]    W_dstE;
  logic [3:0]    W_dstM;
  logic [63:0]   W_valE;
  logic [63:0]   W_valM;
  logic [3:0]    d_srcA;
  logic [3:0]    d_srcB;
  logic [63:0]   d_rvalA;
  logic [63:0]   d_rvalB;
  logic [3:0]    proc_stat;
  logic          halted;
  logic [RW-1:0] retire_cnt;

  int            tests_run;
  int            tests_failed;
  logic [RW-1:0] exp_cnt;

  wb_regfile #(
    .RETIRE_W  (RW),
    .RESET_RSP (64'h200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .W_stall    (W_stall),
    .W_stat     (W_stat),
    .W_icode    (W_icode),
    .W_dstE     (W_dstE),
    .W_dstM     (W_dstM),
    .W_valE     (W_valE),
    .W_valM     (W_valM),
    .d_srcA     (d_srcA),
    .d_srcB     (d_srcB),
    .d_rvalA    (d_rvalA),
    .d_rvalB    (d_rvalB),
    .proc_stat  (proc_stat),
    .halted     (halted),
    .retire_cnt (retire_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_w(input logic [3:0] stat, input logic [3:0] icode,
                         input logic [3:0] dste, input logic [63:0] vale,
                         input logic [3:0] dstm, input logic [63:0] valm);
    W_stat  = stat;
    W_icode = icode;
    W_dstE  = dste;
    W_valE  = vale;
    W_dstM  = dstm;
    W_valM  = valm;
  endtask

  task automatic drive_idle();
    W_stall = 1'b0;
    drive_w(4'h0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
  endtask

  task automatic read_ab(input logic [3:0] a, input logic [3:0] b);
    d_srcA = a;
    d_srcB = b;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    read_ab(4'h4, 4'h0);
    tests_run++;
    if (d_rvalA !== 64'h200) begin
      tests_failed++;
      $display("FAIL reset_rsp: got %h expected %h", d_rvalA, 64'h200);
    end
    tests_run++;
    if (d_rvalB !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_r0: got %h expected %h", d_rvalB, 64'h0);
    end
    tests_run++;
    if (proc_stat !== 4'h1 || halted !== 1'b0 || retire_cnt !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_status: got stat=%h halted=%b cnt=%h expected stat=1 halted=0 cnt=0",
               proc_stat, halted, retire_cnt);
    end
    read_ab(4'hF, 4'hF);
    tests_run++;
    if (d_rvalA !== 64'h0 || d_rvalB !== 64'h0) begin
      tests_failed++;
      $display("FAIL read_rnone: got a=%h b=%h expected 0 0", d_rvalA, d_rvalB);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_commit();
    drive_w(4'h1, 4'h6, 4'h3, 64'hDEAD, 4'hF, 64'h0);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    drive_idle();
    read_ab(4'h3, 4'h4);
    tests_run++;
    if (d_rvalA !== 64'hDEAD) begin
      tests_failed++;
      $display("FAIL commit_e: got %h expected %h", d_rvalA, 64'hDEAD);
    end
    tests_run++;
    if (d_rvalB !== 64'h200) begin
      tests_failed++;
      $display("FAIL commit_other_reg: got %h expected %h", d_rvalB, 64'h200);
    end
    tests_run++;
    if (retire_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL commit_cnt: got %h expected %h", retire_cnt, exp_cnt);
    end
    // Both ports to different registers in one cycle
    drive_w(4'h1, 4'hB, 4'h8, 64'h11, 4'h9, 64'h22);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    drive_idle();
    read_ab(4'h8, 4'h9);
    tests_run++;
    if (d_rvalA !== 64'h11 || d_rvalB !== 64'h22) begin
      tests_failed++;
      $display("FAIL dual_write: got a=%h b=%h expected 11 22", d_rvalA, d_rvalB);
    end
  endtask

  task automatic test_popq();
    drive_w(4'h1, 4'hB, 4'h4, 64'h208, 4'h4, 64'h55);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    drive_idle();
    read_ab(4'h4, 4'h3);
    tests_run++;
    if (d_rvalA !== 64'h55) begin
      tests_failed++;
      $display("FAIL popq_m_wins: got %h expected %h", d_rvalA, 64'h55);
    end
    tests_run++;
    if (retire_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL popq_cnt: got %h expected %h", retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall();
    W_stall = 1'b1;
    drive_w(4'h1, 4'h3, 4'h2, 64'h7, 4'hF, 64'h0);
    tick();
    tick();
    drive_idle();
    read_ab(4'h2, 4'hF);
    tests_run++;
    if (d_rvalA !== 64'h0) begin
      tests_failed++;
      $display("FAIL stall_no_write: got %h expected %h", d_rvalA, 64'h0);
    end
    tests_run++;
    if (retire_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL stall_cnt: got %h expected %h", retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_bypass();
    // Same-cycle read of a register being written: M beats E
    drive_w(4'h1, 4'h5, 4'h7, 64'h1, 4'h7, 64'h9);
    read_ab(4'h7, 4'h3);
    tests_run++;
`ifdef RF_WRITE_BYPASS_EN
    if (d_rvalA !== 64'h9) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle: got %h expected %h", d_rvalA, 64'h9);
    end
`else
    if (d_rvalA !== 64'h0) begin
      tests_failed++;
      $display("FAIL no_bypass_same_cycle: got %h expected %h", d_rvalA, 64'h0);
    end
`endif
    tick();
    exp_cnt = exp_cnt + 1'b1;
    drive_idle();
    read_ab(4'h7, 4'h3);
    tests_run++;
    if (d_rvalA !== 64'h9 || d_rvalB !== 64'hDEAD) begin
      tests_failed++;
      $display("FAIL after_edge_r7: got a=%h b=%h expected 9 dead", d_rvalA, d_rvalB);
    end
  endtask

  task automatic test_bubble_wrap();
    // Bubbles with writes requested must leave everything alone
    for (int i = 0; i < 3; i++) begin
      drive_w(4'h0, 4'h6, 4'hA, 64'h5, 4'hB, 64'h6);
      tick();
      drive_w(4'h0, 4'h1, 4'hA, 64'h5, 4'hF, 64'h0);
      tick();
    end
    drive_idle();
    read_ab(4'hA, 4'hB);
    tests_run++;
    if (d_rvalA !== 64'h0 || d_rvalB !== 64'h0 || retire_cnt !== exp_cnt || proc_stat !== 4'h1) begin
      tests_failed++;
      $display("FAIL bubble_noop: got a=%h b=%h cnt=%h stat=%h expected 0 0 %h 1",
               d_rvalA, d_rvalB, retire_cnt, proc_stat, exp_cnt);
    end
    // Committed nop writes but is not counted
    drive_w(4'h1, 4'h1, 4'hA, 64'h33, 4'hF, 64'h0);
    tick();
    drive_idle();
    read_ab(4'hA, 4'hF);
    tests_run++;
    if (d_rvalA !== 64'h33 || retire_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL nop_commit: got r10=%h cnt=%h expected 33 %h", d_rvalA, retire_cnt, exp_cnt);
    end
    // Count up to all-ones, then wrap
    while (exp_cnt != 4'hF) begin
      drive_w(4'h1, 4'h6, 4'hE, {60'h0, exp_cnt}, 4'hF, 64'h0);
      tick();
      exp_cnt = exp_cnt + 1'b1;
    end
    drive_idle();
    #1;
    tests_run++;
    if (retire_cnt !== 4'hF) begin
      tests_failed++;
      $display("FAIL cnt_all_ones: got %h expected %h", retire_cnt, 4'hF);
    end
    drive_w(4'h1, 4'h2, 4'hF, 64'h0, 4'hF, 64'h0);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    drive_idle();
    #1;
    tests_run++;
    if (retire_cnt !== 4'h0 || exp_cnt !== 4'h0) begin
      tests_failed++;
      $display("FAIL cnt_wrap: got %h expected %h", retire_cnt, 4'h0);
    end
  endtask

  task automatic test_halt();
    drive_w(4'h3, 4'h5, 4'hF, 64'h0, 4'h5, 64'hAA);
    tick();
    drive_w(4'h1, 4'h6, 4'h6, 64'hBB, 4'hF, 64'h0);
    #1;
    tests_run++;
    if (proc_stat !== 4'h3 || halted !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_latch: got stat=%h halted=%b expected 3 1", proc_stat, halted);
    end
    tick();
    drive_w(4'h4, 4'h6, 4'h6, 64'hCC, 4'hF, 64'h0);
    tick();
    drive_idle();
    read_ab(4'h5, 4'h6);
    tests_run++;
    if (d_rvalA !== 64'h0 || d_rvalB !== 64'h0) begin
      tests_failed++;
      $display("FAIL halt_no_write: got r5=%h r6=%h expected 0 0", d_rvalA, d_rvalB);
    end
    tests_run++;
    if (proc_stat !== 4'h3 || retire_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL halt_sticky: got stat=%h cnt=%h expected 3 %h", proc_stat, retire_cnt, exp_cnt);
    end
    // Asynchronous reset clears everything without waiting for an edge
    @(negedge clk);
    rst = 1'b1;
    read_ab(4'h3, 4'h4);
    tests_run++;
    if (proc_stat !== 4'h1 || halted !== 1'b0 || retire_cnt !== 4'h0) begin
      tests_failed++;
      $display("FAIL rst_status: got stat=%h halted=%b cnt=%h expected 1 0 0", proc_stat, halted, retire_cnt);
    end
    tests_run++;
    if (d_rvalA !== 64'h0 || d_rvalB !== 64'h200) begin
      tests_failed++;
      $display("FAIL rst_regs: got r3=%h r4=%h expected 0 200", d_rvalA, d_rvalB);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_after_reset();
    // First edge after reset release commits normally; undefined stat faults
    drive_w(4'h1, 4'h6, 4'h1, 64'h1234, 4'hF, 64'h0);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    drive_w(4'h9, 4'h6, 4'h2, 64'h99, 4'hF, 64'h0);
    tick();
    drive_idle();
    read_ab(4'h1, 4'h2);
    tests_run++;
    if (d_rvalA !== 64'h1234 || d_rvalB !== 64'h0 || retire_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL post_reset_commit: got r1=%h r2=%h cnt=%h expected 1234 0 %h",
               d_rvalA, d_rvalB, retire_cnt, exp_cnt);
    end
    tests_run++;
    if (proc_stat !== 4'h9 || halted !== 1'b1) begin
      tests_failed++;
      $display("FAIL undefined_stat: got stat=%h halted=%b expected 9 1", proc_stat, halted);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_cnt      = '0;
    rst          = 1'b1;
    d_srcA       = 4'hF;
    d_srcB       = 4'hF;
    drive_idle();
    test_reset();
    test_commit();
    test_popq();
    test_stall();
    test_bypass();
    test_bubble_wrap();
    test_halt();
    test_after_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
